// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: reads 16-bit words from program memory, splits them into
// opcode / register select / sign-magnitude immediate and hands them to execute.
module instr_fetch_decode #(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    input  logic              mem_ready,
    output logic [5:0]        opcode,
    output logic              reg_sel,
    output logic [8:0]        nr,
    output logic              seu_en,
    output logic              instr_valid,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StSeu,
        StIssue,
        StWaitExec
    } state_t;

    localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [15:0] ir;

    // Strobes are set on the transition into their state so they align with it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            pc          <= '0;
            ir          <= '0;
            opcode      <= '0;
            reg_sel     <= 1'b0;
            nr          <= '0;
            mem_rd      <= 1'b0;
            seu_en      <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            seu_en      <= 1'b0;
            instr_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state  <= StFetch;
                        mem_rd <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                StFetch: begin
                    if (mem_ready) begin
                        ir     <= mem_data;
                        pc     <= pc + PcOne;
                        mem_rd <= 1'b0;
                        state  <= StDecode;
                    end
                end
                StDecode: begin
                    opcode  <= ir[15:10];
                    reg_sel <= ir[9];
                    nr      <= ir[8:0];
                    if (ir[15:10] == HALT_OP) begin
                        halted <= 1'b1;
                        state  <= StIdle;
                    end else if (ir[15]) begin
                        seu_en <= 1'b1;
                        state  <= StSeu;
                    end else begin
                        instr_valid <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StSeu: begin
                    instr_valid <= 1'b1;
                    state       <= StIssue;
                end
                StIssue: begin
                    state <= StWaitExec;
                end
                StWaitExec: begin
                    if (exec_done) begin
                        mem_rd <= 1'b1;
                        state  <= StFetch;
                    end
                end
                default: begin
                    mem_rd <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

    assign mem_addr = pc;
    assign busy     = (state != StIdle);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: latency-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_instr_fetch_decode;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic [5:0]  opcode;
    logic        reg_sel;
    logic [8:0]  nr;
    logic        seu_en;
    logic        instr_valid;
    logic        exec_done;
    logic [9:0]  pc;
    logic        busy;
    logic        halted;

    int n_chk  = 0;
    int n_pass = 0;

    instr_fetch_decode #(
        .ADDR_W (10),
        .HALT_OP(6'b111111)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .opcode     (opcode),
        .reg_sel    (reg_sel),
        .nr         (nr),
        .seu_en     (seu_en),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: tracks the instruction by cycles elapsed since the word was accepted.
    logic [9:0]  m_pc;
    logic [15:0] m_word;
    logic [5:0]  m_op;
    logic        m_rs;
    logic [8:0]  m_nr;
    logic        m_fetch, m_busy, m_halted, m_seu, m_iv, m_wait;
    int          m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_word = 0; m_op = 0; m_rs = 0; m_nr = 0;
            m_fetch = 0; m_busy = 0; m_halted = 0; m_seu = 0; m_iv = 0; m_wait = 0;
            m_k = -1;
        end else begin
            m_seu = 0;
            m_iv  = 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_fetch = 1; m_halted = 0;
                end
            end else if (m_fetch) begin
                if (mem_ready) begin
                    m_word  = mem_data;
                    m_pc    = 10'((int'(m_pc) + 1) % 1024);
                    m_fetch = 0;
                    m_k     = 0;
                end
            end else if (m_wait) begin
                if (exec_done) begin
                    m_wait = 0; m_fetch = 1;
                end
            end else if (m_k >= 0) begin
                m_k++;
                if (m_k == 1) begin
                    m_op = m_word[15:10];
                    m_rs = m_word[9];
                    m_nr = m_word[8:0];
                    if (m_word[15:10] == 6'h3F) begin
                        m_halted = 1; m_busy = 0; m_k = -1;
                    end
                end
                if (m_k > 0) begin
                    // immediate class spends one extra cycle feeding the sign-extension unit
                    m_seu = m_word[15] && m_k == 1;
                    m_iv  = (m_k == (m_word[15] ? 2 : 1));
                    if (m_k == (m_word[15] ? 3 : 2)) begin
                        m_k = -1; m_wait = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_rd", mem_rd, m_fetch);
            chk("mem_addr", mem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("opcode", opcode, m_op);
            chk("reg_sel", reg_sel, m_rs);
            chk("nr", nr, m_nr);
            chk("seu_en", seu_en, m_seu);
            chk("instr_valid", instr_valid, m_iv);
            chk("busy", busy, m_busy);
            chk("halted", halted, m_halted);
            chk("seu_iv_exclusive", seu_en & instr_valid, 0);
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic logic cond(input int which);
        case (which)
            0: return seu_en;
            1: return instr_valid;
            2: return mem_rd && pc == 10'h3FF;
            3: return mem_rd && pc == 10'h000;
            4: return halted;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, input string name);
        int n = 0;
        while (!cond(which) && n < limit) begin
            tick();
            n++;
        end
        chk(name, cond(which), 1);
    endtask

    initial begin
        rst_n = 0; start = 0; mem_data = 0; mem_ready = 0; exec_done = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        chk("reset_pc", pc, 0);
        chk("reset_busy", busy, 0);
        chk("reset_mem_rd", mem_rd, 0);

        // Immediate instruction, zero-wait memory
        start = 1; mem_data = 16'h8185; mem_ready = 1;
        tick(); start = 0;
        tick(); mem_ready = 0;
        wait_for(0, 10, "seu_en_seen");
        chk("imm_iv_not_with_seu", instr_valid, 0);
        tick();
        chk("imm_seu_one_cycle", seu_en, 0);
        chk("imm_iv_after_seu", instr_valid, 1);
        chk("imm_opcode", opcode, 6'h20);
        chk("imm_reg_sel", reg_sel, 0);
        chk("imm_nr", nr, 9'h185);
        chk("imm_pc", pc, 1);
        tick(); exec_done = 1;
        tick(); exec_done = 0;

        // Non-immediate instruction, 3-cycle memory wait
        for (int i = 0; i < 3; i++) begin
            chk("wait_mem_addr", mem_addr, 10'h001);
            chk("wait_mem_rd", mem_rd, 1);
            tick();
        end
        mem_ready = 1; mem_data = 16'h0203;
        tick(); mem_ready = 0;
        chk("nonimm_decode_no_iv", instr_valid, 0);
        tick();
        chk("nonimm_iv", instr_valid, 1);
        chk("nonimm_opcode", opcode, 6'h00);
        chk("nonimm_reg_sel", reg_sel, 1);
        chk("nonimm_nr", nr, 9'h003);
        tick(); exec_done = 1;
        tick(); exec_done = 0;

        // Back-pressure, with an exec_done pulse during ISSUE that must be ignored
        mem_ready = 1; mem_data = 16'h4A07;
        tick(); mem_ready = 0;
        tick();
        chk("bp_iv", instr_valid, 1);
        exec_done = 1;
        tick(); exec_done = 0;
        repeat (10) tick();
        chk("bp_mem_rd", mem_rd, 0);
        chk("bp_busy", busy, 1);
        chk("bp_opcode", opcode, 6'h12);
        chk("bp_nr", nr, 9'h007);
        exec_done = 1;
        tick(); exec_done = 0;
        chk("bp_refetch_rd", mem_rd, 1);
        chk("bp_refetch_addr", mem_addr, 10'h003);

        // Halt and restart
        mem_ready = 1; mem_data = 16'hFC00;
        tick(); mem_ready = 0;
        tick();
        chk("halt_halted", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_no_iv", instr_valid, 0);
        chk("halt_pc", pc, 10'h004);
        start = 1;
        tick(); start = 0;
        chk("restart_halted", halted, 0);
        chk("restart_addr", mem_addr, 10'h004);
        mem_ready = 1; mem_data = 16'h0001;
        tick(); mem_ready = 0;
        tick();
        tick(); exec_done = 1;
        tick(); exec_done = 0;
        chk("pre_reset_pc", pc, 10'h005);
        chk("pre_reset_fetch", mem_rd, 1);

        // Asynchronous reset mid-fetch
        #2 rst_n = 0;
        #1;
        chk("async_rst_pc", pc, 0);
        chk("async_rst_mem_rd", mem_rd, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_opcode", opcode, 0);
        chk("async_rst_nr", nr, 0);
        repeat (2) tick();
        rst_n = 1;
        tick();

        // PC wrap: run back-to-back non-immediate instructions until pc rolls over
        start = 1; mem_ready = 1; mem_data = 16'h0000; exec_done = 1;
        tick(); start = 0;
        wait_for(2, 6000, "wrap_reach_3ff");
        chk("wrap_addr_3ff", mem_addr, 10'h3FF);
        tick();
        wait_for(3, 20, "wrap_reach_000");
        chk("wrap_pc_0", pc, 10'h000);
        chk("wrap_addr_0", mem_addr, 10'h000);
        mem_data = 16'hFC00;
        wait_for(4, 20, "final_halt");
        mem_ready = 0; exec_done = 0;
        tick();
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
